tb_stream_scheduler: RTL and testbench

//  Sequences the double-buffered (ping-pong) transpose buffer. Issues row reads to
//  the on-chip memory, steers returned rows into the write half and tracks the

---
 rtl/tb_stream_scheduler_if.sv | 31 +++
 rtl/tb_stream_scheduler.sv | 130 +++++++++++++
 tb/tb_tb_stream_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tb_stream_scheduler_if.sv
// rtl/tb_stream_scheduler_if.sv - memory read, buffer write and column handshake bundle for the transpose scheduler
interface tb_stream_scheduler_if #(
    parameter int TB_HEIGHT   = 4,
    parameter int FETCH_WIDTH = 4,
    parameter int ADDR_WIDTH  = 16
);
    localparam int RW = $clog2(TB_HEIGHT);
    localparam int CW = $clog2(FETCH_WIDTH);

    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  tb_wr_en;
    logic                  tb_wr_half;
    logic [RW-1:0]         tb_wr_row;
    logic                  tb_rd_half;
    logic [CW-1:0]         tb_col_index;
    logic                  col_valid;
    logic                  col_ready;

    modport master (
        output mem_ren, mem_addr, tb_wr_en, tb_wr_half, tb_wr_row,
        output tb_rd_half, tb_col_index, col_valid,
        input  col_ready
    );

    modport slave (
        input  mem_ren, mem_addr, tb_wr_en, tb_wr_half, tb_wr_row,
        input  tb_rd_half, tb_col_index, col_valid,
        output col_ready
    );
endinterface

// File: rtl/tb_stream_scheduler.sv
// rtl/tb_stream_scheduler.sv - ping-pong transpose buffer sequencer: row fetch, half tracking, column emission
module tb_stream_scheduler #(
    parameter int TB_HEIGHT   = 4,
    parameter int FETCH_WIDTH = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int TILE_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [TILE_WIDTH-1:0] num_tiles_i,
    output logic                  busy_o,
    output logic                  done_o,
    tb_stream_scheduler_if.master sched
);
    localparam int RW = $clog2(TB_HEIGHT);
    localparam int CW = $clog2(FETCH_WIDTH);
    localparam logic [RW:0]   ROWS_PER_HALF = (RW+1)'(TB_HEIGHT);
    localparam logic [RW-1:0] LAST_ROW      = RW'(TB_HEIGHT - 1);
    localparam logic [CW-1:0] LAST_COL      = CW'(FETCH_WIDTH - 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, total_rows_q;
    logic [TILE_WIDTH-1:0] num_tiles_q, tiles_issued_q, tiles_drained_q;
    logic [RW:0]           rows_issued_q;
    logic [1:0]            full_q, full_d;
    logic                  wr_half_q, rd_half_q;
    logic [CW-1:0]         col_idx_q;
    logic                  wr_en_q, wr_half_d1_q;
    logic [RW-1:0]         wr_row_q;
    logic                  zero_done_q;

    logic run, issue, col_valid, accept, accept_last, fill_done, last_tile, start_ok;

    assign run         = (state_q == S_RUN);
    assign start_ok    = (state_q == S_IDLE) && start_i;
    assign issue       = run && !full_q[wr_half_q] && (rows_issued_q < ROWS_PER_HALF)
                         && (tiles_issued_q < num_tiles_q);
    assign col_valid   = run && full_q[rd_half_q];
    assign accept      = col_valid && sched.col_ready;
    assign accept_last = accept && (col_idx_q == LAST_COL);
    // The returning write of the last row seals the half one cycle later.
    assign fill_done   = wr_en_q && (wr_row_q == LAST_ROW);
    assign last_tile   = (tiles_drained_q == num_tiles_q - TILE_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        full_d  = full_q;
        case (state_q)
            S_IDLE: if (start_ok && (num_tiles_i != '0)) state_d = S_RUN;
            S_RUN:  if (accept_last && last_tile)        state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (fill_done)   full_d[wr_half_d1_q] = 1'b1;
        if (accept_last) full_d[rd_half_q]    = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q          <= '0;
            total_rows_q    <= '0;
            num_tiles_q     <= '0;
            tiles_issued_q  <= '0;
            tiles_drained_q <= '0;
            rows_issued_q   <= '0;
            full_q          <= '0;
            wr_half_q       <= 1'b0;
            rd_half_q       <= 1'b0;
            col_idx_q       <= '0;
            wr_en_q         <= 1'b0;
            wr_half_d1_q    <= 1'b0;
            wr_row_q        <= '0;
            zero_done_q     <= 1'b0;
        end else begin
            full_q       <= full_d;
            wr_en_q      <= issue;
            wr_half_d1_q <= issue ? wr_half_q : 1'b0;
            wr_row_q     <= issue ? rows_issued_q[RW-1:0] : '0;
            zero_done_q  <= start_ok && (num_tiles_i == '0);

            if (start_ok) begin
                base_q          <= base_addr_i;
                num_tiles_q     <= num_tiles_i;
                total_rows_q    <= '0;
                tiles_issued_q  <= '0;
                tiles_drained_q <= '0;
                rows_issued_q   <= '0;
                col_idx_q       <= '0;
            end else begin
                if (issue) begin
                    total_rows_q <= total_rows_q + ADDR_WIDTH'(1);
                    if (rows_issued_q[RW-1:0] == LAST_ROW)
                        tiles_issued_q <= tiles_issued_q + TILE_WIDTH'(1);
                end
                if (fill_done) begin
                    wr_half_q     <= ~wr_half_q;
                    rows_issued_q <= '0;
                end else if (issue) begin
                    rows_issued_q <= rows_issued_q + (RW+1)'(1);
                end
                if (accept_last) begin
                    col_idx_q       <= '0;
                    rd_half_q       <= ~rd_half_q;
                    tiles_drained_q <= tiles_drained_q + TILE_WIDTH'(1);
                end else if (accept) begin
                    col_idx_q <= col_idx_q + CW'(1);
                end
            end
        end
    end

    assign sched.mem_ren      = issue;
    assign sched.mem_addr     = issue ? (base_q + total_rows_q) : '0;
    assign sched.tb_wr_en     = wr_en_q;
    assign sched.tb_wr_half   = wr_half_d1_q;
    assign sched.tb_wr_row    = wr_row_q;
    assign sched.tb_rd_half   = rd_half_q;
    assign sched.tb_col_index = col_idx_q;
    assign sched.col_valid    = col_valid;
    assign busy_o             = run;
    assign done_o             = (accept_last && last_tile) || zero_done_q;
endmodule

// File: tb/tb_tb_stream_scheduler.sv
// tb/tb_tb_stream_scheduler.sv - directed-vector bench for the transpose buffer scheduler
module tb_tb_stream_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [7:0]  num_tiles;
    logic        busy, done;

    always #5 clk = ~clk;

    tb_stream_scheduler_if #(.TB_HEIGHT(4), .FETCH_WIDTH(4), .ADDR_WIDTH(16)) sif ();

    tb_stream_scheduler #(
        .TB_HEIGHT(4), .FETCH_WIDTH(4), .ADDR_WIDTH(16), .TILE_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .base_addr_i(base_addr),
        .num_tiles_i(num_tiles),
        .busy_o     (busy),
        .done_o     (done),
        .sched      (sif)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [2:0]  wr_q[$];
    int          wr_cyc_q[$];
    logic [2:0]  col_q[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          stall_cnt = 0;
    logic        busy_at_done = 1'b0;
    logic        busy_seen = 1'b0;
    logic        rec_en = 1'b0;
    logic        hold_chk = 1'b0;
    logic        stall_p = 1'b0;
    logic [1:0]  held_idx = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (busy) busy_seen = 1'b1;
        if (rec_en) begin
            if (sif.mem_ren) begin
                rd_addr_q.push_back(sif.mem_addr);
                rd_cyc_q.push_back(cyc);
            end
            if (sif.tb_wr_en) begin
                wr_q.push_back({sif.tb_wr_half, sif.tb_wr_row});
                wr_cyc_q.push_back(cyc);
            end
            if (sif.col_valid) valid_cnt++;
            if (sif.col_valid && sif.col_ready) col_q.push_back({sif.tb_rd_half, sif.tb_col_index});
            if (done) begin
                done_cnt++;
                busy_at_done = busy;
            end
            if (hold_chk && stall_p) begin
                check_eq("hold_valid", {31'd0, sif.col_valid}, 32'd1);
                check_eq("hold_index", {30'd0, sif.tb_col_index}, {30'd0, held_idx});
            end
            stall_p  = sif.col_valid && !sif.col_ready;
            held_idx = sif.tb_col_index;
            if (stall_p) stall_cnt++;
        end
    end

    task automatic clear_log();
        rd_addr_q.delete(); rd_cyc_q.delete(); wr_q.delete(); wr_cyc_q.delete(); col_q.delete();
        done_cnt = 0; valid_cnt = 0; stall_cnt = 0; stall_p = 1'b0; busy_seen = 1'b0;
    endtask

    task automatic do_reset();
        rec_en = 1'b0; hold_chk = 1'b0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_tiles = '0; sif.col_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();
    endtask

    task automatic start_stream(input logic [15:0] base, input logic [7:0] tiles);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_tiles = tiles;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget, input logic toggle);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            if (toggle) sif.col_ready = ~sif.col_ready;
            n++;
        end
        check_eq({tag, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
        check_eq({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done_count"}, done_cnt, 32'd1);
        rec_en = 1'b0;
    endtask

    // Every tile fills one half in row order; halves alternate starting at 0 after reset.
    task automatic check_stream(input string tag, input logic [15:0] base, input int tiles);
        logic [15:0] ea;
        logic [2:0]  ev;
        check_eq({tag, "_n_reads"}, rd_addr_q.size(), tiles * 4);
        check_eq({tag, "_n_writes"}, wr_q.size(), tiles * 4);
        check_eq({tag, "_n_cols"}, col_q.size(), tiles * 4);
        for (int i = 0; i < rd_addr_q.size(); i++) begin
            ea = base + 16'(i);
            check_eq($sformatf("%s_addr%0d", tag, i), {16'd0, rd_addr_q[i]}, {16'd0, ea});
            if (i % 4 != 0)
                check_eq($sformatf("%s_rdcyc%0d", tag, i), rd_cyc_q[i], rd_cyc_q[i-1] + 1);
        end
        for (int i = 0; i < wr_q.size(); i++) begin
            ev = {1'((i / 4) % 2), 2'(i % 4)};
            check_eq($sformatf("%s_wr%0d", tag, i), {29'd0, wr_q[i]}, {29'd0, ev});
            if (i < rd_cyc_q.size())
                check_eq($sformatf("%s_wrlat%0d", tag, i), wr_cyc_q[i], rd_cyc_q[i] + 1);
        end
        for (int i = 0; i < col_q.size(); i++) begin
            ev = {1'((i / 4) % 2), 2'(i % 4)};
            check_eq($sformatf("%s_col%0d", tag, i), {29'd0, col_q[i]}, {29'd0, ev});
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_mem_ren"},   {31'd0, sif.mem_ren},      32'd0);
        check_eq({tag, "_mem_addr"},  {16'd0, sif.mem_addr},     32'd0);
        check_eq({tag, "_wr_en"},     {31'd0, sif.tb_wr_en},     32'd0);
        check_eq({tag, "_wr_half"},   {31'd0, sif.tb_wr_half},   32'd0);
        check_eq({tag, "_wr_row"},    {30'd0, sif.tb_wr_row},    32'd0);
        check_eq({tag, "_rd_half"},   {31'd0, sif.tb_rd_half},   32'd0);
        check_eq({tag, "_col_index"}, {30'd0, sif.tb_col_index}, 32'd0);
        check_eq({tag, "_col_valid"}, {31'd0, sif.col_valid},    32'd0);
        check_eq({tag, "_busy"},      {31'd0, busy},             32'd0);
        check_eq({tag, "_done"},      {31'd0, done},             32'd0);
    endtask

    initial begin
        int n;
        do_reset();
        @(negedge clk);
        check_outputs_zero("reset");

        // 1: single tile, consumer always ready
        do_reset();
        sif.col_ready = 1'b1; rec_en = 1'b1;
        start_stream(16'h0010, 8'd1);
        run_until_done("t1", 100, 1'b0);
        check_stream("t1", 16'h0010, 1);
        check_eq("t1_valid_cycles", valid_cnt, 32'd4);

        // 2: three tiles, consumer always ready
        do_reset();
        sif.col_ready = 1'b1; rec_en = 1'b1;
        start_stream(16'h0100, 8'd3);
        run_until_done("t2", 200, 1'b0);
        check_stream("t2", 16'h0100, 3);

        // 3: consumer stalled until both halves are full
        do_reset();
        sif.col_ready = 1'b0; rec_en = 1'b1;
        start_stream(16'h0200, 8'd3);
        repeat (30) @(posedge clk);
        #1;
        check_eq("t3_reads_blocked", rd_addr_q.size(), 32'd8);
        check_eq("t3_ren_low", {31'd0, sif.mem_ren}, 32'd0);
        check_eq("t3_valid_held", {31'd0, sif.col_valid}, 32'd1);
        check_eq("t3_no_cols", col_q.size(), 32'd0);
        sif.col_ready = 1'b1;
        run_until_done("t3", 200, 1'b0);
        check_stream("t3", 16'h0200, 3);

        // 4: alternating ready
        do_reset();
        sif.col_ready = 1'b1; rec_en = 1'b1; hold_chk = 1'b1;
        start_stream(16'h0300, 8'd2);
        run_until_done("t4", 300, 1'b1);
        hold_chk = 1'b0;
        check_stream("t4", 16'h0300, 2);
        check_eq("t4_stalls_seen", {31'd0, stall_cnt > 0}, 32'd1);

        // 5: address wrap
        do_reset();
        sif.col_ready = 1'b1; rec_en = 1'b1;
        start_stream(16'hFFFE, 8'd1);
        run_until_done("t5", 100, 1'b0);
        check_stream("t5", 16'hFFFE, 1);

        // 6: reset mid-stream, then zero-tile start
        do_reset();
        sif.col_ready = 1'b1; rec_en = 1'b1;
        start_stream(16'h0400, 8'd3);
        n = 0;
        while (rd_addr_q.size() < 6 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t6_reached_tile2", {31'd0, rd_addr_q.size() >= 6}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("t6_rst");
        @(negedge clk);
        check_eq("t6_dropped_wr", {31'd0, sif.tb_wr_en}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rec_en = 1'b0;
        busy_seen = 1'b0;
        start_stream(16'h0500, 8'd0);
        @(negedge clk);
        check_eq("t6_zero_done", {31'd0, done}, 32'd1);
        check_eq("t6_zero_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("t6_done_pulse", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_busy_never", {31'd0, busy_seen}, 32'd0);
        check_eq("t6_no_reads", {31'd0, sif.mem_ren}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
